// File: rtl/deserializador_4b.sv
// deserializador_4b: serial-to-parallel receiver with selectable bit order,
// valid/ack handshake and sticky overrun flag.
module deserializador_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             s_in,
  input  logic             dir,
  input  logic             sync,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             ovr,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_n, st_b;
  logic [WIDTH-1:0] sr, sr_n, sr_b, ins, q_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_b;
  logic             dir_l, dir_l_n, d, done, load, valid_n, ovr_n;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      dir_l <= 1'b0;
      q     <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      dir_l <= dir_l_n;
      q     <= q_n;
      valid <= valid_n;
      ovr   <= ovr_n;
      busy  <= cnt_n != '0;
    end
  // sync first rewinds the frame, so a bit accepted alongside it starts a new one
  always_comb begin
    st_b    = sync ? IDLE : state;
    cnt_b   = sync ? '0 : cnt;
    sr_b    = sync ? '0 : sr;
    d       = (st_b == IDLE) ? dir : dir_l;
    ins     = d ? {s_in, sr_b[WIDTH-1:1]} : {sr_b[WIDTH-2:0], s_in};
    done    = enb && st_b == SHIFT && cnt_b == CW'(WIDTH - 1);
    load    = done && (!valid || ack);
    sr_n    = enb ? ins : sr_b;
    cnt_n   = !enb ? cnt_b : done ? '0 : cnt_b + 1'b1;
    state_n = !enb ? st_b : done ? IDLE : SHIFT;
    dir_l_n = (enb && st_b == IDLE) ? dir : dir_l;
    q_n     = load ? ins : q;
    valid_n = load | (valid & ~ack);
    ovr_n   = ovr | (done & valid & ~ack);
  end
endmodule

// File: tb/tb_deserializador_4b.sv
// tb_deserializador_4b: directed and random stimulus checked every cycle against a frame-level model.
module tb_deserializador_4b;
  localparam int W = 4;
  logic clk = 1'b0, reset_L = 1'b0;
  logic enb = 1'b0, s_in = 1'b0, dir = 1'b0, sync = 1'b0, ack = 1'b0;
  logic [W-1:0] q;
  logic valid, ovr, busy;
  int checks = 0, errors = 0;

  deserializador_4b #(.WIDTH(W)) dut (
    .clk(clk), .reset_L(reset_L), .enb(enb), .s_in(s_in), .dir(dir),
    .sync(sync), .ack(ack), .q(q), .valid(valid), .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         valid, ovr, d;
    logic [W-1:0] b;
    logic [2:0]   n;
  } mst_t;
  mst_t m;

  // Frame model: collect bits in arrival order, weight them by position once the frame is full.
  function automatic mst_t nxt(mst_t c, logic e, logic s, logic dr, logic sy, logic a);
    mst_t r = c;
    int w = 0;
    if (sy) r.n = 0;
    if (c.valid && a) r.valid = 1'b0;
    if (e) begin
      if (r.n == 0) r.d = dr;
      r.b[r.n] = s;
      r.n = r.n + 1;
      if (r.n == W) begin
        for (int i = 0; i < W; i++) w += int'(r.b[i]) * (2 ** (r.d ? i : W - 1 - i));
        if (!c.valid || a) begin
          r.q = w[W-1:0];
          r.valid = 1'b1;
        end else r.ovr = 1'b1;
        r.n = 0;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_L)
    if (!reset_L) m <= '0;
    else m <= nxt(m, enb, s_in, dir, sync, ack);

  always @(negedge clk) begin
    checks++;
    if (q !== m.q || valid !== m.valid || ovr !== m.ovr || busy !== (m.n != 0)) begin
      errors++;
      $display("FAIL cycle@%0t: q=%h valid=%b ovr=%b busy=%b expected q=%h valid=%b ovr=%b busy=%b",
               $time, q, valid, ovr, busy, m.q, m.valid, m.ovr, m.n != 0);
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic s, input logic dr, input logic sy, input logic a);
    enb = e; s_in = s; dir = dr; sync = sy; ack = a;
    @(negedge clk);
  endtask

  task automatic word(input logic [W-1:0] v, input logic dr, input logic a_last);
    for (int i = 0; i < W; i++)
      cyc(1'b1, dr ? v[i] : v[W-1-i], dr, 1'b0, (i == W - 1) ? a_last : 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_q", q, '0);
    chk("reset_flags", {valid, ovr, busy}, '0);
    reset_L = 1'b1;
    cyc(0, 0, 0, 0, 0);
    // MSB first
    word(4'b1010, 1'b0, 1'b0);
    chk("msb_q", q, 4'b1010);
    chk("msb_valid_busy", {valid, busy}, 2'b10);
    cyc(0, 0, 0, 0, 1);
    chk("msb_ack_valid", valid, 0);
    chk("msb_ack_q", q, 4'b1010);
    // LSB first with a gap and dir toggled mid-frame
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("gap_busy", busy, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("lsb_gap_q", q, 4'b0001);
    chk("lsb_gap_valid", valid, 1);
    cyc(0, 0, 0, 0, 1);
    // overrun
    word(4'b1100, 1'b0, 1'b0);
    word(4'b0011, 1'b0, 1'b0);
    chk("ovr_q", q, 4'b1100);
    chk("ovr_flags", {valid, ovr}, 2'b11);
    cyc(0, 0, 0, 0, 1);
    chk("ovr_sticky", {valid, ovr}, 2'b01);
    // asynchronous reset mid-cycle
    word(4'b0111, 1'b0, 1'b0);
    cyc(1, 1, 0, 0, 0);
    @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    chk("async_q", q, '0);
    chk("async_flags", {valid, ovr, busy}, '0);
    @(negedge clk);
    reset_L = 1'b1;
    // completion and ack on the same edge
    word(4'b1111, 1'b0, 1'b0);
    word(4'b0110, 1'b0, 1'b1);
    chk("simul_q", q, 4'b0110);
    chk("simul_flags", {valid, ovr}, 2'b10);
    cyc(0, 0, 0, 0, 1);
    // sync realign
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("sync_q", q, 4'b1001);
    cyc(0, 0, 0, 0, 1);
    // reset kills a partial frame
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    reset_L = 1'b0;
    cyc(1, 1, 0, 0, 0);
    reset_L = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("rst_frame_lost", {valid, busy}, 2'b00);
    word(4'b0101, 1'b0, 1'b0);
    chk("fresh_q", q, 4'b0101);
    cyc(0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) reset_L = 1'b0;
      else reset_L = 1'b1;
      cyc(($urandom % 4) != 0, $urandom % 2, $urandom % 2, ($urandom % 16) == 0, ($urandom % 3) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
